reader_pie_tx: RTL and testbench
================================

Name: reader_pie_tx

Overview:
Reader-side (interrogator) command transmitter for the Gen2-style link that the tag receiver decodes. It converts a latched command word into PIE (pulse-interval encoded) modulation: delimiter, data-0, RTcal, optional TRcal, then data symbols MSB first. It sits in the reader/test-harness domain and drives the tag's demodulator input (modout=1 carrier high, 0 carrier low pulse). All timing is in clk cycles.

Parameters:
TARI, 16, data-0 symbol length in clk cycles; data-1 = 2*TARI, RTcal = 3*TARI
PW, 8, low-pulse width at end of every symbol (PW < TARI)
DELIM, 12, delimiter low time in clk cycles
MAXBITS, 64, width of command data register

Ports:
clk  input  1  master clock
reset  input  1  asynchronous active-high reset
start  input  1  begin a frame; sampled only in IDLE
preamble  input  1  1 = full preamble (includes TRcal), 0 = frame-sync
trcal  input  10  TRcal length in clk cycles; must exceed PW
nbits  input  7  number of data bits to send (0..MAXBITS)
din  input  MAXBITS  command bits; din[nbits-1] sent first, din[0] last
modout  output  1  PIE modulation, 1 = carrier on
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset: asynchronous, active-high; modout=1, busy=0, done=0, FSM=IDLE, counters cleared. Reset mid-frame aborts immediately; no partial symbol completes.
- All outputs registered; single clock domain.
- IDLE: modout=1, busy=0. On a clk edge with start=1, latch preamble, trcal, din, and nbits. nbits>MAXBITS is clamped to MAXBITS. Enter DELIM; busy=1 and modout=0 from that edge.
- start while busy is ignored; input changes after latch have no effect.
- States: IDLE -> DELIM -> SYNC0 -> RTCAL -> [TRCAL if preamble] -> DATA (repeat per bit) -> DONE -> IDLE.
- DELIM: modout=0 for DELIM cycles.
- Every symbol state has a high phase of (L-PW) cycles with modout=1, followed by a low phase of PW cycles with modout=0. Symbol lengths L:
  - SYNC0: L=TARI
  - RTCAL: L=3*TARI
  - TRCAL: L=trcal
  - DATA: L=TARI for bit 0, L=2*TARI for bit 1
- Phase counter is 12 bits wide and reloads at each phase boundary, so there are no gap cycles between symbols.
- DATA: a bit index starts at nbits-1 and decrements after each low phase. After the bit-0 low phase, go to DONE. If nbits=0, DATA is skipped: go RTCAL/TRCAL -> DONE.
- DONE: lasts one cycle; done=1, busy=0, modout=1; then IDLE. A new start can be accepted on the first IDLE cycle.
- Frame length in busy cycles = DELIM + TARI + 3*TARI + (preamble ? trcal : 0) + sum of bit lengths.
- trcal<=PW is illegal input. Behaviour: high phase length 0, low phase PW; no lockup.

Test Plan:
1. Reset, hold 5 cycles -> modout=1, busy=0, done=0. Release with start=0 for 20 cycles -> outputs unchanged.
2. Frame-sync: preamble=0, nbits=4, din=4'b1010, defaults. Required modout sequence:
   - low 12
   - high 8 / low 8
   - high 40 / low 8
   - high 24 / low 8
   - high 8 / low 8
   - high 24 / low 8
   - high 8 / low 8
   Then busy=1 for exactly 172 cycles, done pulses 1 cycle, modout stays 1.
3. Preamble: preamble=1, trcal=100, nbits=0 -> delim 12, data-0 16, RTcal 48, TRcal (high 92 / low 8). busy=176 cycles, then done.
4. Clamp and latch: nbits=100, din all ones -> exactly 64 data-1 symbols (32 cycles each). Changing din and asserting start mid-frame has no effect on the waveform or frame length.
5. Reset mid-DATA: assert reset during a low phase -> modout=1 in the same cycle without waiting for an edge; busy=0; no done pulse. After release, a new frame (test 2 stimulus) reproduces the exact waveform of test 2.
6. Back-to-back: start held high continuously -> a second frame's delimiter begins on the cycle after DONE. modout=1 for exactly the DONE cycle between frames.

Source files
------------

// File: rtl/reader_pie_tx.sv
// reader_pie_tx: reader-side PIE command transmitter.
// Latches a command on start and plays out:
//   delimiter, data-0, RTcal, [TRcal], data bits (MSB first).
// Every symbol is a high phase of (L-PW) cycles followed by a low pulse of
// PW cycles. All outputs are registered from next-state values, so modout
// and busy change on the same edge that moves the FSM.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   start          - begin a frame (accepted in IDLE or on the DONE cycle)
//   preamble       - 1 = include TRcal, 0 = frame-sync
//   trcal[9:0]     - TRcal length in clk cycles
//   nbits[6:0]     - data bit count, clamped to MAXBITS
//   din[MAXBITS-1:0] - command bits, din[nbits-1] sent first
//   modout         - 1 = carrier on, 0 = low pulse
//   busy           - frame in progress
//   done           - one-cycle pulse at frame end
module reader_pie_tx #(
    parameter int TARI    = 16,
    parameter int PW      = 8,
    parameter int DELIM   = 12,
    parameter int MAXBITS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               preamble,
    input  logic [9:0]         trcal,
    input  logic [6:0]         nbits,
    input  logic [MAXBITS-1:0] din,
    output logic               modout,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = (MAXBITS > 1) ? $clog2(MAXBITS) : 1;
    localparam logic [11:0] HI_D0   = 12'(TARI - PW);
    localparam logic [11:0] HI_D1   = 12'(2 * TARI - PW);
    localparam logic [11:0] HI_RT   = 12'(3 * TARI - PW);
    localparam logic [11:0] PW_C    = 12'(PW);
    localparam logic [11:0] DELIM_C = 12'(DELIM);
    localparam logic [6:0]  MAXB_C  = 7'(MAXBITS);

    typedef enum logic [2:0] {
        S_IDLE, S_DELIM, S_SYNC0, S_RTCAL, S_TRCAL, S_DATA, S_DONE
    } state_t;

    state_t             state, nxt_state;
    logic               low_q, nxt_low;      // 1 = in low phase (or delimiter)
    logic [11:0]        cnt_q, nxt_cnt;      // cycles left in current phase
    logic [IDX_W-1:0]   idx_q, nxt_idx;      // current data bit index
    logic               pre_q;
    logic [9:0]         trcal_q;
    logic [6:0]         nbits_q;
    logic [MAXBITS-1:0] din_q;
    logic               latch, enter;
    logic [11:0]        trcal_hi, sym_hi;

    // An illegal trcal<=PW collapses TRcal to a bare low pulse.
    assign trcal_hi = ({2'b00, trcal_q} > PW_C) ? ({2'b00, trcal_q} - PW_C) : 12'd0;

    always_comb begin
        nxt_state = state;
        nxt_low   = low_q;
        nxt_cnt   = cnt_q - 12'd1;
        nxt_idx   = idx_q;
        latch     = 1'b0;
        enter     = 1'b0;
        sym_hi    = HI_D0;

        case (state)
            S_IDLE, S_DONE: begin
                // DONE also accepts start so back-to-back frames have only
                // the single DONE cycle of carrier between them.
                nxt_low = 1'b0;
                nxt_cnt = 12'd0;
                if (start) begin
                    nxt_state = S_DELIM;
                    nxt_low   = 1'b1;
                    nxt_cnt   = DELIM_C;
                    latch     = 1'b1;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_DELIM: begin
                if (cnt_q == 12'd1) begin
                    nxt_state = S_SYNC0;
                    enter     = 1'b1;
                end
            end
            default: begin
                if (cnt_q == 12'd1) begin
                    if (!low_q) begin
                        nxt_low = 1'b1;
                        nxt_cnt = PW_C;
                    end else if (state == S_SYNC0) begin
                        nxt_state = S_RTCAL;
                        enter     = 1'b1;
                    end else if (state == S_RTCAL && pre_q) begin
                        nxt_state = S_TRCAL;
                        enter     = 1'b1;
                    end else if (state == S_RTCAL || state == S_TRCAL) begin
                        if (nbits_q == 7'd0) begin
                            nxt_state = S_DONE;
                        end else begin
                            nxt_state = S_DATA;
                            nxt_idx   = IDX_W'(nbits_q - 7'd1);
                            enter     = 1'b1;
                        end
                    end else if (idx_q == '0) begin
                        nxt_state = S_DONE;
                    end else begin
                        nxt_idx = idx_q - IDX_W'(1);
                        enter   = 1'b1;
                    end
                end
            end
        endcase

        case (nxt_state)
            S_SYNC0: sym_hi = HI_D0;
            S_RTCAL: sym_hi = HI_RT;
            S_TRCAL: sym_hi = trcal_hi;
            default: sym_hi = din_q[nxt_idx] ? HI_D1 : HI_D0;
        endcase

        // Symbol entry: skip a zero-length high phase straight to the pulse.
        if (enter) begin
            if (sym_hi == 12'd0) begin
                nxt_low = 1'b1;
                nxt_cnt = PW_C;
            end else begin
                nxt_low = 1'b0;
                nxt_cnt = sym_hi;
            end
        end

        if (nxt_state == S_DONE) begin
            nxt_low = 1'b0;
            nxt_cnt = 12'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            low_q   <= 1'b0;
            cnt_q   <= 12'd0;
            idx_q   <= '0;
            pre_q   <= 1'b0;
            trcal_q <= 10'd0;
            nbits_q <= 7'd0;
            din_q   <= '0;
            modout  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= nxt_state;
            low_q <= nxt_low;
            cnt_q <= nxt_cnt;
            idx_q <= nxt_idx;
            if (latch) begin
                pre_q   <= preamble;
                trcal_q <= trcal;
                nbits_q <= (nbits > MAXB_C) ? MAXB_C : nbits;
                din_q   <= din;
            end
            modout <= ~nxt_low;
            busy   <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done   <= (nxt_state == S_DONE);
        end
    end
endmodule

// File: tb/tb_reader_pie_tx.sv
// Bench for reader_pie_tx: builds the expected per-cycle {modout,busy,done}
// trace of a frame from the symbol-length rules and compares it cycle by
// cycle, with directed cases plus randomized frames.
module tb_reader_pie_tx;
    localparam int TARI = 16;
    localparam int PW = 8;
    localparam int DELIM = 12;
    localparam int MAXBITS = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic preamble = 1'b0;
    logic [9:0] trcal = 10'd0;
    logic [6:0] nbits = 7'd0;
    logic [MAXBITS-1:0] din = '0;
    logic modout, busy, done;

    int n_chk = 0;
    int n_bad = 0;
    int last_busy = 0;
    logic [2:0] exp_q[$];

    reader_pie_tx #(.TARI(TARI), .PW(PW), .DELIM(DELIM), .MAXBITS(MAXBITS)) dut (
        .clk(clk), .reset(reset), .start(start), .preamble(preamble),
        .trcal(trcal), .nbits(nbits), .din(din),
        .modout(modout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference trace entries are {modout, busy, done}.
    task automatic add_sym(input int len);
        int hi;
        hi = (len > PW) ? len - PW : 0;
        repeat (hi) exp_q.push_back(3'b110);
        repeat (PW) exp_q.push_back(3'b010);
    endtask

    task automatic add_frame(input bit pre, input int tr, input int nb, input logic [MAXBITS-1:0] d);
        int n;
        repeat (DELIM) exp_q.push_back(3'b010);
        add_sym(TARI);
        add_sym(3 * TARI);
        if (pre) add_sym(tr);
        n = (nb > MAXBITS) ? MAXBITS : nb;
        for (int b = n - 1; b >= 0; b--) add_sym(d[b] ? 2 * TARI : TARI);
        exp_q.push_back(3'b101);
    endtask

    // Plays one frame (or two back-to-back with start held) and checks every
    // cycle. perturb_at >= 0 disturbs the inputs and pulses start mid-frame.
    task automatic run_frame(input string tag, input bit pre, input int tr, input int nb,
                             input logic [MAXBITS-1:0] d, input bit twice, input int perturb_at);
        int len1, drop_at;
        exp_q.delete();
        add_frame(pre, tr, nb, d);
        len1 = exp_q.size();
        if (twice) add_frame(pre, tr, nb, d);
        drop_at = twice ? len1 : 0;
        @(negedge clk);
        preamble = pre; trcal = tr[9:0]; nbits = nb[6:0]; din = d; start = 1'b1;
        last_busy = 0;
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk(tag, 32'({modout, busy, done}), 32'(exp_q[i]));
            if (busy) last_busy++;
            if (i == drop_at) start = 1'b0;
            if (i == perturb_at) begin
                din = ~d; nbits = 7'd1; preamble = ~pre; trcal = 10'd3; start = 1'b1;
            end else if (perturb_at >= 0 && i == perturb_at + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_idle"}, 32'({modout, busy, done}), 32'(3'b100));
    endtask

    initial begin
        logic [MAXBITS-1:0] rd;
        int rn, rt;
        bit rp;

        // Reset state and quiet idle.
        #2 reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst", 32'({modout, busy, done}), 32'(3'b100));
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle", 32'({modout, busy, done}), 32'(3'b100));
        end

        // Frame-sync, din=1010.
        run_frame("fsync", 1'b0, 0, 4, 64'hA, 1'b0, -1);
        chk("fsync_busy", 32'(last_busy), 32'd172);

        // Full preamble, no data.
        run_frame("pre", 1'b1, 100, 0, 64'h0, 1'b0, -1);
        chk("pre_busy", 32'(last_busy), 32'd176);

        // Illegal trcal below the pulse width.
        run_frame("trc_ill", 1'b1, 5, 2, 64'h2, 1'b0, -1);

        // Clamp to MAXBITS and ignore mid-frame input changes/start.
        run_frame("clamp", 1'b0, 0, 100, '1, 1'b0, 500);
        chk("clamp_busy", 32'(last_busy), 32'(DELIM + 4 * TARI + 64 * 2 * TARI));

        // Reset during the low phase of the first data bit.
        exp_q.delete();
        add_frame(1'b0, 0, 4, 64'hA);
        @(negedge clk);
        preamble = 1'b0; nbits = 7'd4; din = 64'hA; start = 1'b1;
        for (int i = 0; i <= 102; i++) begin
            @(negedge clk);
            chk("rst_mid_pre", 32'({modout, busy, done}), 32'(exp_q[i]));
            if (i == 0) start = 1'b0;
        end
        reset = 1'b1;
        #1 chk("rst_async", 32'({modout, busy, done}), 32'(3'b100));
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", 32'({modout, busy, done}), 32'(3'b100));
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel", 32'({modout, busy, done}), 32'(3'b100));
        run_frame("after_rst", 1'b0, 0, 4, 64'hA, 1'b0, -1);
        chk("after_rst_busy", 32'(last_busy), 32'd172);

        // Back-to-back with start held across the DONE cycle.
        run_frame("b2b", 1'b0, 0, 4, 64'hA, 1'b1, -1);
        chk("b2b_busy", 32'(last_busy), 32'd344);

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            rp = 1'($urandom_range(0, 1));
            rt = $urandom_range(1, 300);
            rn = (k < 4) ? $urandom_range(0, 20) : $urandom_range(0, 127);
            rd = {$urandom, $urandom};
            run_frame("rand", rp, rt, rn, rd, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
